// File: rtl/tff_seq_pkg.sv
// Shared types and default widths for the T flip-flop toggle sequencer.
package tff_seq_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_t;

  // Latched command; count also serves as the remaining-pulse counter.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] count;
    logic [GAP_W_DEF-1:0] gap;
  } cmd_t;

endpackage

// File: rtl/tff_toggle_seq_gap_timer.sv
// Loadable down-counter that times the idle gap between toggle pulses.
module tff_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (dec && value_reg != '0) begin
      value_reg <= value_reg - 1'b1;
    end
  end

  assign value  = value_reg;
  // Expires on the last idle cycle so the following cycle is the next pulse.
  assign expire = (value_reg == W'(1));

endmodule

// File: rtl/tff_toggle_seq.sv
// Command-driven toggle sequencer feeding a T flip-flop's t input.
// Define TFF_SEQ_CHECK_EN to verify each toggle against the fed-back q.
module tff_toggle_seq
  import tff_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             cmd_abort,
  output logic             t,
  input  logic             q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [CNT_W-1:0] toggles_done
);

  state_t           state_reg, state_next;
  cmd_t             cmd_reg, cmd_next;
  logic [CNT_W-1:0] toggles_reg, toggles_next;
  logic             err_flag_reg, err_flag_next;
  logic             abort_flag_reg, abort_flag_next;
  logic             t_reg;
  logic             gap_load, gap_dec, gap_expire;
  logic [GAP_W-1:0] gap_value;
  logic             check_fail;

`ifdef TFF_SEQ_CHECK_EN
  logic expected_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_reg <= 1'b0;
    end else if (state_reg == S_PULSE) begin
      expected_reg <= ~q;
    end
  end

  assign check_fail = (q != expected_reg);
`else
  logic unused_q;
  assign unused_q   = q;
  assign check_fail = 1'b0;
`endif

  tff_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (cmd_reg.gap),
    .dec      (gap_dec),
    .value    (gap_value),
    .expire   (gap_expire)
  );

  assign cmd_ready = (state_reg == S_IDLE) && !rst;

  always_comb begin
    state_next      = state_reg;
    cmd_next        = cmd_reg;
    toggles_next    = toggles_reg;
    err_flag_next   = err_flag_reg;
    abort_flag_next = abort_flag_reg;
    gap_load        = 1'b0;
    gap_dec         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_next.count  = cmd_count;
          cmd_next.gap    = cmd_gap;
          toggles_next    = '0;
          err_flag_next   = 1'b0;
          abort_flag_next = 1'b0;
          state_next      = (cmd_count == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (cmd_abort) begin
          abort_flag_next = 1'b1;
          state_next      = S_DONE;
        end else begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        // The check is recorded even when an abort arrives in this cycle.
        if (check_fail) err_flag_next = 1'b1;
        if (toggles_reg != '1) toggles_next = toggles_reg + 1'b1;
        if (cmd_reg.count != '0) cmd_next.count = cmd_reg.count - 1'b1;
        if (cmd_abort) begin
          abort_flag_next = 1'b1;
          state_next      = S_DONE;
        end else if (cmd_reg.count[CNT_W_DEF-1:1] == '0) begin
          state_next = S_DONE;
        end else if (cmd_reg.gap == '0) begin
          state_next = S_PULSE;
        end else begin
          gap_load   = 1'b1;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        gap_dec = 1'b1;
        if (cmd_abort) begin
          abort_flag_next = 1'b1;
          state_next      = S_DONE;
        end else if (gap_expire || gap_value == '0) begin
          state_next = S_PULSE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      cmd_reg        <= '0;
      toggles_reg    <= '0;
      err_flag_reg   <= 1'b0;
      abort_flag_reg <= 1'b0;
      t_reg          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cmd_reg        <= cmd_next;
      toggles_reg    <= toggles_next;
      err_flag_reg   <= err_flag_next;
      abort_flag_reg <= abort_flag_next;
      // Registered so t is high exactly while the state register reads PULSE.
      t_reg          <= (state_next == S_PULSE);
    end
  end

  assign t            = t_reg;
  assign busy         = (state_reg == S_PULSE) || (state_reg == S_CHECK) || (state_reg == S_GAP);
  assign done         = (state_reg == S_DONE);
  assign err          = done && err_flag_reg;
  assign aborted      = done && abort_flag_reg;
  assign toggles_done = toggles_reg;

endmodule
